sel_mux_pipe: RTL and testbench
===============================

SEL_MUX_PIPE -- requirements
Module: sel_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data width of every channel and of the output.
REQ-002 Parameter CHANNELS, default 4, legal range 2..8: number of input channels.
REQ-003 Parameter RR_MODE, default 0: 0 = channel chosen by sel; 1 = round-robin arbitration among valid channels, sel ignored.
REQ-004 Derived constant SW = clog2(CHANNELS): width of sel and out_ch.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 sel  input  SW  channel select, used only when RR_MODE=0.
REQ-008 in_data  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_valid  input  CHANNELS  per-channel valid.
REQ-010 in_ready  output  CHANNELS  per-channel ready; at most one bit set per cycle.
REQ-011 out_data  output  WIDTH  data word at the buffer head.
REQ-012 out_ch  output  SW  index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data and out_ch are valid.
REQ-014 out_ready  input  1  downstream accepts the head word.

Function
REQ-015 A transfer on channel k occurs in any cycle with in_valid[k] and in_ready[k] both high; a pop occurs in any cycle with out_valid and out_ready both high.
REQ-016 Output stage: 2-entry FIFO of {data, channel}, states EMPTY (0 entries), ONE (1), FULL (2).
REQ-017 Transitions: EMPTY→ONE on push; ONE→FULL on push without pop; ONE→EMPTY on pop without push; ONE→ONE on simultaneous push and pop; FULL→ONE on pop. No push is accepted in FULL.
REQ-018 Latency: a word accepted in cycle t appears on out_data with out_valid high in cycle t+1 when the FIFO was empty or popped in cycle t.
REQ-019 Throughput: one word per cycle sustained while out_ready stays high.
REQ-020 Ordering: words leave in acceptance order; out_ch tracks its word.
REQ-021 out_valid SHALL be high exactly in states ONE and FULL; out_data and out_ch are driven from registers only.
REQ-022 RR_MODE=0: in_ready[sel] = not FULL; all other in_ready bits are 0.
REQ-023 RR_MODE=0, sel >= CHANNELS: all in_ready are 0, no push occurs, and no X is produced.
REQ-024 RR_MODE=1: grant goes to the first valid channel at or after the priority pointer, wrapping modulo CHANNELS; in_ready[grant] = not FULL; no valid channel means no grant.
REQ-025 RR_MODE=1: after a transfer on channel g, the pointer becomes (g+1) mod CHANNELS; otherwise it holds.
REQ-026 in_ready SHALL depend combinationally only on state, sel, pointer and in_valid, never on out_ready.
REQ-027 Changing sel while the FIFO is non-empty SHALL NOT alter buffered words.

Reset
REQ-028 Asserting reset_n low SHALL immediately force: state EMPTY, out_valid 0, out_data 0, out_ch 0, pointer 0, all in_ready 0.
REQ-029 Reset asserted mid-operation SHALL discard buffered words; no word is emitted after deassertion until a new push.
REQ-030 in_ready SHALL stay 0 while reset_n is low and may rise in the first cycle after deassertion.

Structure
REQ-031 The shared package SHALL hold the FIFO state encoding (EMPTY/ONE/FULL) and the default WIDTH/CHANNELS constants used across the datapath.
REQ-032 Round-robin grant logic SHALL be a separate sub-module, rr_arbiter, parametrised by CHANNELS; it is instantiated only when RR_MODE=1.

Verification
REQ-033 RR_MODE=0, CHANNELS=4, sel=2, in_data ch2=16'h00A5, in_valid=4'b0100, out_ready=1 → out_data=16'h00A5, out_ch=2, out_valid=1 one cycle later.
REQ-034 out_ready=0 with 3 words pushed on ch1 (16'h0001, 16'h0002, 16'h0003) → first two accepted, in_ready[1]=0 on the third; after out_ready=1, outputs read 1, 2, then 3.
REQ-035 RR_MODE=1, in_valid=4'b1111 held, out_ready=1 → out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-036 RR_MODE=1, pointer=3, in_valid=4'b0011 → grant 0, then 1, then 0.
REQ-037 RR_MODE=0, CHANNELS=3, sel=3 with in_valid=3'b111 → in_ready=0 and out_valid stays 0 for 10 cycles.
REQ-038 FULL with two words, reset_n pulsed low mid-cycle → out_valid falls immediately; after release out_valid stays 0 until the next accepted push.

Source files
------------

// File: rtl/sel_mux_pipe_pkg.sv
// Shared definitions for the channel-select mux and its output buffer:
// default datapath sizes, the buffer occupancy encoding and a small index helper.
package sel_mux_pipe_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 4;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_st_t;

  // Index following idx among n channels, wrapping back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sel_mux_pipe_arb.sv
// Round-robin arbiter: grants the first requesting channel at or after the
// priority pointer; the pointer moves past a channel once it has transferred.
module rr_arbiter
  import sel_mux_pipe_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] i_req,
  input  logic                i_xfer,
  output logic                o_gnt_vld,
  output logic [SW-1:0]       o_gnt_idx
);

  logic [SW-1:0]       r_ptr;
  logic [CHANNELS-1:0] w_rot;
  logic                w_hit;
  int                  w_off;
  int                  w_sum;
  logic [SW-1:0]       w_idx;

  // Rotate requests so bit 0 is the pointer's channel, then pick the lowest set offset.
  always_comb begin
    w_rot = CHANNELS'({i_req, i_req} >> r_ptr);
    w_hit = 1'b0;
    w_off = 0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_hit = 1'b1;
        w_off = j;
      end
    end
    w_sum = int'(r_ptr) + w_off;
    if (w_sum >= CHANNELS) w_sum = w_sum - CHANNELS;
    w_idx = SW'(w_sum);
  end

  // Advance the pointer just past the channel that completed a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_xfer && w_hit) begin
      r_ptr <= SW'(wrap_inc(int'(w_idx), CHANNELS));
    end
  end

  assign o_gnt_vld = w_hit;
  assign o_gnt_idx = w_idx;

endmodule

// File: rtl/sel_mux_pipe.sv
// Channel mux feeding a two-entry output buffer. The source channel is chosen
// either by sel or by a round-robin arbiter; each buffered word carries the
// index of the channel it came from.
module sel_mux_pipe
  import sel_mux_pipe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int RR_MODE  = 0,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SW-1:0]             sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SW-1:0]             out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  fifo_st_t         r_state;
  logic [WIDTH-1:0] r_h_data;
  logic [SW-1:0]    r_h_ch;
  logic [WIDTH-1:0] r_t_data;
  logic [SW-1:0]    r_t_ch;

  logic             w_gnt_vld;
  logic [SW-1:0]    w_gnt_idx;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_push_data;

  generate
    if (RR_MODE == 1) begin : g_rr
      rr_arbiter #(
        .CHANNELS (CHANNELS)
      ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (in_valid),
        .i_xfer    (w_push),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
      );
    end else begin : g_sel
      // An out-of-range select grants nobody, so no channel is ever offered ready.
      assign w_gnt_vld = (int'(sel) < CHANNELS);
      assign w_gnt_idx = sel;
    end
  endgenerate

  assign w_full    = (r_state == ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_pop     = out_valid && out_ready;
  assign w_push    = |(in_valid & in_ready);

  // Shift rather than part-select so an unused out-of-range index yields zeros, never X.
  assign w_push_data = WIDTH'(in_data >> (int'(w_gnt_idx) * WIDTH));

  // One-hot ready toward the granted channel; low in reset and whenever the buffer is full.
  always_comb begin
    in_ready = '0;
    if (reset_n && w_gnt_vld && !w_full) begin
      in_ready = CHANNELS'(1) << w_gnt_idx;
    end
  end

  // Occupancy and head entry; the head registers drive the outputs directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_EMPTY;
      r_h_data <= '0;
      r_h_ch   <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_state  <= ST_ONE;
            r_h_data <= w_push_data;
            r_h_ch   <= w_gnt_idx;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_h_data <= w_push_data;
            r_h_ch   <= w_gnt_idx;
          end else if (w_push) begin
            r_state <= ST_FULL;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_state  <= ST_ONE;
            r_h_data <= r_t_data;
            r_h_ch   <= r_t_ch;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Second entry is written only when a word arrives behind a head that stays put.
  always_ff @(posedge clk) begin
    if (r_state == ST_ONE && w_push && !w_pop) begin
      r_t_data <= w_push_data;
      r_t_ch   <= w_gnt_idx;
    end
  end

  assign out_data = r_h_data;
  assign out_ch   = r_h_ch;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Bench for sel_mux_pipe: three instances (select mode with 4 and 3 channels,
// round-robin with 4) share one stimulus stream and are each compared every
// cycle against a queue model of the buffered words.
module tb_sel_mux_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [15:0] od0, od1, od2;
  logic [1:0]  oc0, oc1, oc2;
  logic        ov0, ov1, ov2;

  sel_mux_pipe #(.WIDTH(16), .CHANNELS(4), .RR_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .out_data(od0), .out_ch(oc0), .out_valid(ov0), .out_ready(out_ready));

  sel_mux_pipe #(.WIDTH(16), .CHANNELS(4), .RR_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .out_data(od1), .out_ch(oc1), .out_valid(ov1), .out_ready(out_ready));

  sel_mux_pipe #(.WIDTH(16), .CHANNELS(3), .RR_MODE(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .sel(sel), .in_data(in_data[47:0]), .in_valid(in_valid[2:0]),
    .in_ready(rdy2), .out_data(od2), .out_ch(oc2), .out_valid(ov2), .out_ready(out_ready));

  // Model: per instance, a queue of {channel, data} in acceptance order plus the RR pointer.
  logic [31:0] q [3][$];
  int          ptr  [3];
  int          mode [3] = '{0, 1, 0};
  int          nch  [3] = '{4, 4, 3};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [3:0] exp_ready(input int k);
    logic [3:0] r;
    int c;
    r = '0;
    if (!reset_n || q[k].size() >= 2) return r;
    if (mode[k] == 0) begin
      if (int'(sel) < nch[k]) r[sel] = 1'b1;
    end else begin
      for (int i = 0; i < nch[k]; i++) begin
        c = (ptr[k] + i) % nch[k];
        if (in_valid[c]) begin
          r[c] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] o_rdy(input int k);
    case (k)
      0:       return rdy0;
      1:       return rdy1;
      default: return {1'b0, rdy2};
    endcase
  endfunction

  function automatic logic o_vld(input int k);
    case (k)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [15:0] o_dat(input int k);
    case (k)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  function automatic logic [1:0] o_ch(input int k);
    case (k)
      0:       return oc0;
      1:       return oc1;
      default: return oc2;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      ptr[k] = 0;
    end
  endtask

  task automatic check_all();
    logic [31:0] h;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ready%0d", k), 64'(o_rdy(k)), 64'(exp_ready(k)));
      chk($sformatf("valid%0d", k), 64'(o_vld(k)), 64'(q[k].size() > 0));
      if (q[k].size() > 0) begin
        h = q[k][0];
        chk($sformatf("data%0d", k), 64'(o_dat(k)), 64'(h[15:0]));
        chk($sformatf("ch%0d", k), 64'(o_ch(k)), 64'(h[31:16]));
      end
    end
  endtask

  task automatic reset_chk(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_ready%0d", tag, k), 64'(o_rdy(k)), 64'(0));
      chk($sformatf("%s_valid%0d", tag, k), 64'(o_vld(k)), 64'(0));
      chk($sformatf("%s_data%0d", tag, k), 64'(o_dat(k)), 64'(0));
      chk($sformatf("%s_ch%0d", tag, k), 64'(o_ch(k)), 64'(0));
    end
  endtask

  // Apply the accept/pop rules for the edge that just happened.
  task automatic model_update();
    logic [3:0] x;
    int g;
    for (int k = 0; k < 3; k++) begin
      x = exp_ready(k) & in_valid;
      g = -1;
      for (int c = 0; c < 4; c++) if (x[c]) g = c;
      if (q[k].size() > 0 && out_ready) void'(q[k].pop_front());
      if (g >= 0) begin
        q[k].push_back({16'(g), in_data[g*16 +: 16]});
        if (mode[k] == 1) ptr[k] = (g + 1) % nch[k];
      end
    end
  endtask

  task automatic mid();
    @(negedge clk);
    check_all();
  endtask

  task automatic edge_upd();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    mid();
    edge_upd();
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    model_clear();
    #1;
    reset_chk(tag);
    @(posedge clk);
    #1;
    reset_chk({tag, "_held"});
    reset_n = 1'b1;
  endtask

  logic [1:0] rr_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] gnt_seq [3] = '{4'b0001, 4'b0010, 4'b0001};

  initial begin
    reset_n   = 1'b0;
    sel       = 2'd0;
    in_data   = '0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    model_clear();
    #1;
    reset_chk("rst0");
    repeat (2) @(posedge clk);
    #1;
    reset_chk("rst0_held");
    reset_n  = 1'b1;
    in_valid = 4'b0000;
    cyc();

    // Single word on channel 2 appears one cycle later.
    sel       = 2'd2;
    in_data   = {$urandom, $urandom};
    in_data[47:32] = 16'h00A5;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    cyc();
    in_valid = 4'b0000;
    mid();
    chk("a5_data", 64'(od0), 64'(16'h00A5));
    chk("a5_ch", 64'(oc0), 64'(2));
    chk("a5_valid", 64'(ov0), 64'(1));
    edge_upd();
    cyc();

    // Round-robin pointer now sits at 3; channels 0 and 1 requesting.
    sel      = 2'd0;
    in_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("rr_wrap_gnt%0d", i), 64'(rdy1), 64'(gnt_seq[i]));
      edge_upd();
    end
    in_valid = 4'b0000;
    repeat (3) cyc();

    // Backpressure: two words fill the buffer, the third waits.
    sel       = 2'd1;
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    in_data[31:16] = 16'h0001;
    cyc();
    in_data[31:16] = 16'h0002;
    cyc();
    in_data[31:16] = 16'h0003;
    mid();
    chk("bp_ready_full", 64'(rdy0), 64'(0));
    edge_upd();
    out_ready = 1'b1;
    mid();
    chk("bp_read1", 64'(od0), 64'(16'h0001));
    edge_upd();
    mid();
    chk("bp_read2", 64'(od0), 64'(16'h0002));
    chk("bp_ready_again", 64'(rdy0), 64'(4'b0010));
    edge_upd();
    in_valid = 4'b0000;
    mid();
    chk("bp_read3", 64'(od0), 64'(16'h0003));
    edge_upd();
    cyc();

    // All channels requesting: round-robin visits 0,1,2,3,0.
    do_reset("rst1");
    in_valid  = 4'b1111;
    in_data   = {$urandom, $urandom};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mid();
      if (i > 0) begin
        chk($sformatf("rr_seq%0d", i - 1), 64'(oc1), 64'(rr_seq[i - 1]));
        chk($sformatf("rr_vld%0d", i - 1), 64'(ov1), 64'(1));
      end
      edge_upd();
    end

    // Out-of-range select on the 3-channel instance never accepts anything.
    do_reset("rst2");
    sel      = 2'd3;
    in_valid = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk($sformatf("oor_ready%0d", i), 64'(rdy2), 64'(0));
      chk($sformatf("oor_valid%0d", i), 64'(ov2), 64'(0));
      edge_upd();
    end

    // Reset while full discards both words.
    sel       = 2'd1;
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    repeat (2) cyc();
    mid();
    chk("full_before_rst", 64'(ov0), 64'(1));
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    reset_chk("rst_mid");
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("post_rst_valid%0d", i), 64'(ov0), 64'(0));
      edge_upd();
    end
    in_valid = 4'b0010;
    cyc();
    in_valid = 4'b0000;
    mid();
    chk("post_rst_push", 64'(ov0), 64'(1));
    edge_upd();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_data   = {$urandom, $urandom};
      in_valid  = 4'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
